// File: rtl/cal_input.sv
// cal_input: debounced two-operand entry FSM with a valid/ready handoff
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   confirm, exit     raw bouncing push-buttons (high = pressed)
//   sw[2:0]           raw operand switches
//   op_ready          consumer accepts the operand pair
//   op_valid          op_a/op_b hold a complete pair (registered)
//   op_a, op_b        latched operands
//   phase             FSM state: 00 ENTER_A, 01 ENTER_B, 10 OFFER, 11 DONE
//   leds              {op_a, op_b, phase}
module cal_input #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       confirm,
  input  logic       exit,
  input  logic [2:0] sw,
  input  logic       op_ready,
  output logic       op_valid,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic [1:0] phase,
  output logic [7:0] leds
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  typedef enum logic [1:0] {ENTER_A = 2'b00, ENTER_B = 2'b01, OFFER = 2'b10, DONE = 2'b11} state_t;
  state_t state;
  // bit 0 = confirm, bit 1 = exit
  logic [1:0] b_s1, b_s2, deb, deb_d, pulse;
  logic [2:0] sw_s1, sw_s2;
  logic [CW-1:0] cnt [2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_s1  <= '0;
      b_s2  <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      b_s1  <= {exit, confirm};
      b_s2  <= b_s1;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  // debounced level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deb    <= '0;
      deb_d  <= '0;
      pulse  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      for (int i = 0; i < 2; i++)
        if (b_s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ENTER_A;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (pulse[1]) begin
      state    <= ENTER_A;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else
      case (state)
        ENTER_A: if (pulse[0]) begin
          op_a  <= sw_s2;
          state <= ENTER_B;
        end
        ENTER_B: if (pulse[0]) begin
          op_b     <= sw_s2;
          op_valid <= 1'b1;
          state    <= OFFER;
        end
        OFFER: if (op_valid && op_ready) begin
          op_valid <= 1'b0;
          state    <= DONE;
        end
        default: if (pulse[0]) begin
          op_a  <= '0;
          op_b  <= '0;
          state <= ENTER_A;
        end
      endcase
  assign phase = state;
  assign leds  = {op_a, op_b, phase};
endmodule
